// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - sizing helpers and response classification for the fetch front end
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    RSP_NONE,
    RSP_FILL,
    RSP_DROP,
    RSP_ORPHAN
  } rsp_kind_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int pc_step(input int instr_w);
    return instr_w / 8;
  endfunction

endpackage

// File: rtl/fetch_slot_ring.sv
// rtl/fetch_slot_ring.sv - DEPTH-slot {pc, instr} ring with alloc/fill/rd pointers
// Slots are allocated at request accept, filled at response, and drained at pop.
module fetch_slot_ring import fetch_unit_pkg::*; #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4,
  localparam int IDX_W  = clog2(DEPTH),
  localparam int PTR_W  = IDX_W + 1
) (
  input  logic               clock_i,
  input  logic               clear_i,
  input  logic               alloc_i,
  input  logic [ADDR_W-1:0]  alloc_pc_i,
  input  logic               fill_i,
  input  logic [INSTR_W-1:0] fill_instr_i,
  input  logic               pop_i,
  output logic [PTR_W-1:0]   occ_o,
  output logic [PTR_W-1:0]   inflight_o,
  output logic               head_valid_o,
  output logic [ADDR_W-1:0]  head_pc_o,
  output logic [INSTR_W-1:0] head_instr_o
);

  logic [PTR_W-1:0]   alloc_q, fill_q, rd_q;
  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  always_ff @(posedge clock_i) begin
    if (clear_i) begin
      alloc_q <= '0;
      fill_q  <= '0;
      rd_q    <= '0;
    end else begin
      if (alloc_i) alloc_q <= alloc_q + PTR_W'(1);
      if (fill_i)  fill_q  <= fill_q + PTR_W'(1);
      if (pop_i)   rd_q    <= rd_q + PTR_W'(1);
    end
  end

  // Slot contents need no reset: they are only visible behind the pointers.
  always_ff @(posedge clock_i) begin
    if (!clear_i && alloc_i) pc_mem[alloc_q[IDX_W-1:0]]   <= alloc_pc_i;
    if (!clear_i && fill_i)  instr_mem[fill_q[IDX_W-1:0]] <= fill_instr_i;
  end

  assign occ_o        = alloc_q - rd_q;
  assign inflight_o   = alloc_q - fill_q;
  assign head_valid_o = (fill_q != rd_q);
  assign head_pc_o    = pc_mem[rd_q[IDX_W-1:0]];
  assign head_instr_o = instr_mem[rd_q[IDX_W-1:0]];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end: PC, request gating, stale-response drop, IF/ID queue
// Redirects clear the ring; responses already in flight are counted in drop_q and discarded on return.
module fetch_unit import fetch_unit_pkg::*; #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clock_i,
  input  logic               reset_i,
  output logic               imem_req_valid_o,
  input  logic               imem_req_ready_i,
  output logic [ADDR_W-1:0]  imem_req_addr_o,
  input  logic               imem_rsp_valid_i,
  input  logic [INSTR_W-1:0] imem_rsp_data_i,
  input  logic               redirect_valid_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic               if_valid_o,
  input  logic               if_ready_i,
  output logic [INSTR_W-1:0] if_instr_o,
  output logic [ADDR_W-1:0]  if_pc_o,
  output logic [ADDR_W-1:0]  if_pc_next_o,
  output logic               err_rsp_o
);

  localparam int                PTR_W   = clog2(DEPTH) + 1;
  localparam int                DROP_W  = clog2(2 * DEPTH + 1);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(pc_step(INSTR_W));

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [DROP_W-1:0]  drop_q, drop_d;
  logic               err_q, err_d;

  logic [PTR_W-1:0]   occ, inflight;
  logic               head_valid;
  logic [ADDR_W-1:0]  head_pc;
  logic [INSTR_W-1:0] head_instr;
  logic               accept, pop, clear, rsp_consumed;
  rsp_kind_e          rsp_kind;

  always_comb begin
    imem_req_valid_o = !reset_i && !redirect_valid_i && (occ < PTR_W'(DEPTH));
    accept           = imem_req_valid_o && imem_req_ready_i;
    pop              = head_valid && if_ready_i;
    clear            = reset_i || redirect_valid_i;

    rsp_kind = RSP_NONE;
    if (imem_rsp_valid_i) begin
      if (drop_q != '0)        rsp_kind = RSP_DROP;
      else if (inflight != '0) rsp_kind = RSP_FILL;
      else                     rsp_kind = RSP_ORPHAN;
    end
    rsp_consumed = (rsp_kind == RSP_DROP) || (rsp_kind == RSP_FILL);

    pc_d   = pc_q;
    drop_d = drop_q;
    err_d  = err_q || (rsp_kind == RSP_ORPHAN);
    if (redirect_valid_i) begin
      pc_d   = redirect_pc_i;
      // This cycle's response belongs to the discarded stream, so it retires one stale entry.
      drop_d = drop_q + DROP_W'(inflight) - DROP_W'(rsp_consumed);
    end else begin
      if (accept)                 pc_d   = pc_q + PC_STEP;
      if (rsp_kind == RSP_DROP)   drop_d = drop_q - DROP_W'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
      err_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
      err_q  <= err_d;
    end
  end

  fetch_slot_ring #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W),
    .DEPTH  (DEPTH)
  ) u_ring (
    .clock_i     (clock_i),
    .clear_i     (clear),
    .alloc_i     (accept),
    .alloc_pc_i  (pc_q),
    .fill_i      (rsp_kind == RSP_FILL),
    .fill_instr_i(imem_rsp_data_i),
    .pop_i       (pop),
    .occ_o       (occ),
    .inflight_o  (inflight),
    .head_valid_o(head_valid),
    .head_pc_o   (head_pc),
    .head_instr_o(head_instr)
  );

  assign imem_req_addr_o = pc_q;
  assign err_rsp_o       = err_q;
  assign if_valid_o      = head_valid;
  assign if_instr_o      = head_valid ? head_instr : '0;
  assign if_pc_o         = head_valid ? head_pc : '0;
  assign if_pc_next_o    = head_valid ? head_pc + PC_STEP : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed scenario bench for fetch_unit with a fixed-latency in-order memory
module tb_fetch_unit;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 4;

  logic               clock_i = 1'b0;
  logic               reset_i;
  logic               imem_req_valid_o;
  logic               imem_req_ready_i;
  logic [ADDR_W-1:0]  imem_req_addr_o;
  logic               imem_rsp_valid_i;
  logic [INSTR_W-1:0] imem_rsp_data_i;
  logic               redirect_valid_i;
  logic [ADDR_W-1:0]  redirect_pc_i;
  logic               if_valid_o;
  logic               if_ready_i;
  logic [INSTR_W-1:0] if_instr_o;
  logic [ADDR_W-1:0]  if_pc_o;
  logic [ADDR_W-1:0]  if_pc_next_o;
  logic               err_rsp_o;

  always #5 clock_i = ~clock_i;

  fetch_unit #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clock_i         (clock_i),
    .reset_i         (reset_i),
    .imem_req_valid_o(imem_req_valid_o),
    .imem_req_ready_i(imem_req_ready_i),
    .imem_req_addr_o (imem_req_addr_o),
    .imem_rsp_valid_i(imem_rsp_valid_i),
    .imem_rsp_data_i (imem_rsp_data_i),
    .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i   (redirect_pc_i),
    .if_valid_o      (if_valid_o),
    .if_ready_i      (if_ready_i),
    .if_instr_o      (if_instr_o),
    .if_pc_o         (if_pc_o),
    .if_pc_next_o    (if_pc_next_o),
    .err_rsp_o       (err_rsp_o)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int lat         = 1;
  int accepts     = 0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic tick();
    if (imem_req_valid_o && imem_req_ready_i) begin
      pend_addr.push_back(imem_req_addr_o);
      pend_due.push_back(cyc + lat);
      accepts++;
    end
    @(posedge clock_i);
    #1;
    cyc++;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = '0;
    if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = mem_word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    redirect_valid_i = 1'b0;
    tick();
    tick();
    pend_addr.delete();
    pend_due.delete();
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = '0;
    reset_i = 1'b0;
    accepts = 0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    #1;
    vectors++; if (imem_req_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid_o); end
    vectors++; if (if_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_if_valid: got %b want 0", if_valid_o); end
    vectors++; if ({if_instr_o, if_pc_o, if_pc_next_o} !== 96'h0) begin miscompares++; $display("FAIL reset_if_data: got %h/%h/%h want 0", if_instr_o, if_pc_o, if_pc_next_o); end
    vectors++; if (err_rsp_o !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err_rsp_o); end
    pend_addr.delete();
    pend_due.delete();
    reset_i = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] want;
    imem_req_ready_i = 1'b1;
    if_ready_i = 1'b1;
    lat = 1;
    for (int k = 0; k < 8; k++) begin
      #1;
      want = 32'(4 * k);
      vectors++; if ({imem_req_valid_o, imem_req_addr_o} !== {1'b1, want}) begin miscompares++; $display("FAIL stream_req k=%0d: got %b/%h want 1/%h", k, imem_req_valid_o, imem_req_addr_o, want); end
      if (k >= 2) begin
        want = 32'(4 * (k - 2));
        vectors++;
        if ({if_valid_o, if_pc_o, if_instr_o, if_pc_next_o} !== {1'b1, want, mem_word(want), want + 32'd4}) begin
          miscompares++;
          $display("FAIL stream_if k=%0d: got %b/%h/%h/%h want 1/%h/%h/%h", k, if_valid_o, if_pc_o, if_instr_o, if_pc_next_o, want, mem_word(want), want + 32'd4);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] want;
    lat = 1;
    imem_req_ready_i = 1'b1;
    if_ready_i = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) begin #1; tick(); end
    #1;
    vectors++; if (accepts !== 4) begin miscompares++; $display("FAIL bp_accepts: got %0d want 4", accepts); end
    vectors++; if (imem_req_valid_o !== 1'b0) begin miscompares++; $display("FAIL bp_req_valid_full: got %b want 0", imem_req_valid_o); end
    if_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      want = 32'(4 * i);
      vectors++; if ({if_valid_o, if_pc_o} !== {1'b1, want}) begin miscompares++; $display("FAIL bp_drain i=%0d: got %b/%h want 1/%h", i, if_valid_o, if_pc_o, want); end
      if (i == 1) begin
        vectors++; if ({imem_req_valid_o, imem_req_addr_o} !== {1'b1, 32'h10}) begin miscompares++; $display("FAIL bp_req_resume: got %b/%h want 1/00000010", imem_req_valid_o, imem_req_addr_o); end
      end
      tick();
    end
  endtask

  task automatic test_redirect_drop();
    int waited;
    lat = 3;
    imem_req_ready_i = 1'b1;
    if_ready_i = 1'b1;
    do_reset();
    #1; tick();
    #1; tick();
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'h40;
    #1;
    vectors++; if (imem_req_valid_o !== 1'b0) begin miscompares++; $display("FAIL rd_req_in_redirect: got %b want 0", imem_req_valid_o); end
    tick();
    redirect_valid_i = 1'b0;
    waited = 0;
    while (waited < 10) begin
      #1;
      if (if_valid_o) break;
      tick();
      waited++;
    end
    vectors++; if ({if_valid_o, if_pc_o, if_instr_o} !== {1'b1, 32'h40, mem_word(32'h40)}) begin miscompares++; $display("FAIL rd_first_if: got %b/%h/%h want 1/00000040/%h", if_valid_o, if_pc_o, if_instr_o, mem_word(32'h40)); end
    vectors++; if (waited !== 4) begin miscompares++; $display("FAIL rd_latency: got %0d cycles want 4", waited); end
    vectors++; if (err_rsp_o !== 1'b0) begin miscompares++; $display("FAIL rd_err: got %b want 0", err_rsp_o); end
    tick();
    #1;
    vectors++; if ({if_valid_o, if_pc_o} !== {1'b1, 32'h44}) begin miscompares++; $display("FAIL rd_second_if: got %b/%h want 1/00000044", if_valid_o, if_pc_o); end
  endtask

  task automatic test_redirect_collide();
    int first_i, stale;
    logic [31:0] first_pc;
    lat = 1;
    imem_req_ready_i = 1'b1;
    if_ready_i = 1'b1;
    do_reset();
    #1; tick();
    #1; tick();
    #1;
    vectors++; if ({if_valid_o, if_pc_o, imem_rsp_valid_i} !== {1'b1, 32'h0, 1'b1}) begin miscompares++; $display("FAIL rc_setup: got %b/%h/%b want 1/00000000/1", if_valid_o, if_pc_o, imem_rsp_valid_i); end
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'h100;
    #1;
    tick();
    redirect_valid_i = 1'b0;
    first_i = -1;
    first_pc = '0;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (if_valid_o) begin
        if (if_pc_o < 32'h100) stale++;
        if (first_i < 0) begin first_i = i; first_pc = if_pc_o; end
      end
      tick();
    end
    vectors++; if (first_pc !== 32'h100) begin miscompares++; $display("FAIL rc_first_pc: got %h want 00000100", first_pc); end
    vectors++; if (first_i !== 2) begin miscompares++; $display("FAIL rc_first_cycle: got %0d want 2", first_i); end
    vectors++; if (stale !== 0) begin miscompares++; $display("FAIL rc_stale: got %0d stale pcs want 0", stale); end
    vectors++; if (err_rsp_o !== 1'b0) begin miscompares++; $display("FAIL rc_err: got %b want 0", err_rsp_o); end
  endtask

  task automatic test_orphan_rsp();
    lat = 1;
    imem_req_ready_i = 1'b0;
    if_ready_i = 1'b1;
    do_reset();
    #1;
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i = 32'hBAD0_BAD0;
    #1;
    tick();
    #1;
    vectors++; if ({err_rsp_o, if_valid_o} !== 2'b10) begin miscompares++; $display("FAIL orphan_err: got err=%b if_valid=%b want 1/0", err_rsp_o, if_valid_o); end
    imem_req_ready_i = 1'b1;
    tick();
    #1; tick();
    #1;
    vectors++; if ({if_valid_o, if_pc_o, if_instr_o} !== {1'b1, 32'h0, mem_word(32'h0)}) begin miscompares++; $display("FAIL orphan_queue: got %b/%h/%h want 1/00000000/%h", if_valid_o, if_pc_o, if_instr_o, mem_word(32'h0)); end
    vectors++; if (err_rsp_o !== 1'b1) begin miscompares++; $display("FAIL orphan_sticky: got %b want 1", err_rsp_o); end
    do_reset();
    #1;
    vectors++; if (err_rsp_o !== 1'b0) begin miscompares++; $display("FAIL orphan_cleared: got %b want 0", err_rsp_o); end
  endtask

  task automatic test_pc_wrap();
    lat = 1;
    imem_req_ready_i = 1'b0;
    if_ready_i = 1'b1;
    do_reset();
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    #1; tick();
    redirect_valid_i = 1'b0;
    imem_req_ready_i = 1'b1;
    #1;
    vectors++; if (imem_req_addr_o !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_addr0: got %h want fffffffc", imem_req_addr_o); end
    tick();
    #1;
    vectors++; if (imem_req_addr_o !== 32'h0) begin miscompares++; $display("FAIL wrap_addr1: got %h want 00000000", imem_req_addr_o); end
    tick();
    #1;
    vectors++; if ({if_valid_o, if_pc_o, if_pc_next_o} !== {1'b1, 32'hFFFF_FFFC, 32'h0}) begin miscompares++; $display("FAIL wrap_if: got %b/%h/%h want 1/fffffffc/00000000", if_valid_o, if_pc_o, if_pc_next_o); end
  endtask

  task automatic test_reset_midop();
    lat = 1;
    imem_req_ready_i = 1'b0;
    if_ready_i = 1'b0;
    do_reset();
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'h10;
    #1; tick();
    redirect_valid_i = 1'b0;
    imem_req_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin #1; tick(); end
    imem_req_ready_i = 1'b0;
    #1; tick();
    #1; tick();
    #1;
    vectors++; if ({if_valid_o, if_pc_o, imem_req_addr_o} !== {1'b1, 32'h10, 32'h1C}) begin miscompares++; $display("FAIL rm_setup: got %b/%h/%h want 1/00000010/0000001c", if_valid_o, if_pc_o, imem_req_addr_o); end
    vectors++; if (accepts !== 3) begin miscompares++; $display("FAIL rm_accepts: got %0d want 3", accepts); end
    reset_i = 1'b1;
    #1;
    vectors++; if (imem_req_valid_o !== 1'b0) begin miscompares++; $display("FAIL rm_req_in_reset: got %b want 0", imem_req_valid_o); end
    tick();
    #1;
    vectors++; if ({if_valid_o, if_pc_o, if_instr_o} !== {1'b0, 32'h0, 32'h0}) begin miscompares++; $display("FAIL rm_if_cleared: got %b/%h/%h want 0/0/0", if_valid_o, if_pc_o, if_instr_o); end
    reset_i = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    imem_rsp_valid_i = 1'b0;
    #1;
    vectors++; if ({imem_req_valid_o, imem_req_addr_o} !== {1'b1, 32'h0}) begin miscompares++; $display("FAIL rm_restart: got %b/%h want 1/00000000", imem_req_valid_o, imem_req_addr_o); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i          = 1'b1;
    imem_req_ready_i = 1'b1;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = '0;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = '0;
    if_ready_i       = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_redirect_collide();
    test_orphan_rsp();
    test_pc_wrap();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
